// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the pipelined EX-stage ALU.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    OpAdd      = 5'd0,
    OpSub      = 5'd1,
    OpAnd      = 5'd2,
    OpOr       = 5'd3,
    OpSh1add   = 5'd4,
    OpSh2add   = 5'd5,
    OpSh3add   = 5'd6,
    OpAddUw    = 5'd7,
    OpSh1addUw = 5'd8,
    OpSh2addUw = 5'd9,
    OpSh3addUw = 5'd10,
    OpSlliUw   = 5'd11,
    OpXor      = 5'd12,
    OpSll      = 5'd13,
    OpSrl      = 5'd14,
    OpSra      = 5'd15,
    OpAddw     = 5'd16,
    OpSubw     = 5'd17,
    OpSlt      = 5'd18,
    OpSltu     = 5'd19
  } alu_op_e;

  function automatic logic is_legal_op(logic [ALU_OP_W-1:0] op);
    return op <= OpSltu;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV64I/Zba ALU datapath; unknown opcodes give zero and flag illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     result,
  output logic                illegal
);

  localparam int unsigned SH = $clog2(XLEN);

  logic [SH-1:0]   shamt;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] a_uw;
  logic [XLEN-1:0] addw;
  logic [XLEN-1:0] subw;

  assign shamt = b[SH-1:0];
  assign sum   = a + b;
  assign diff  = a - b;

  // On RV32 the .uw and word forms collapse onto the plain ops.
  if (XLEN == 64) begin : gen_rv64
    assign a_uw = {32'b0, a[31:0]};
    assign addw = {{32{sum[31]}}, sum[31:0]};
    assign subw = {{32{diff[31]}}, diff[31:0]};
  end else begin : gen_rv32
    assign a_uw = a;
    assign addw = sum;
    assign subw = diff;
  end

  always_comb begin
    result  = '0;
    illegal = !is_legal_op(op);
    case (alu_op_e'(op))
      OpAdd:      result = sum;
      OpSub:      result = diff;
      OpAnd:      result = a & b;
      OpOr:       result = a | b;
      OpSh1add:   result = b + (a << 1);
      OpSh2add:   result = b + (a << 2);
      OpSh3add:   result = b + (a << 3);
      OpAddUw:    result = b + a_uw;
      OpSh1addUw: result = b + (a_uw << 1);
      OpSh2addUw: result = b + (a_uw << 2);
      OpSh3addUw: result = b + (a_uw << 3);
      OpSlliUw:   result = a_uw << shamt;
      OpXor:      result = a ^ b;
      OpSll:      result = a << shamt;
      OpSrl:      result = a >> shamt;
      OpSra:      result = $unsigned($signed(a) >>> shamt);
      OpAddw:     result = addw;
      OpSubw:     result = subw;
      OpSlt:      result = XLEN'($signed(a) < $signed(b));
      OpSltu:     result = XLEN'(a < b);
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined EX-stage ALU: valid/ready handshake, tag passthrough, collapsing bubbles and flush.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned PIPE_DEPTH = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [XLEN-1:0]     in_src_a,
  input  logic [XLEN-1:0]     in_src_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic                out_zero,
  output logic                out_illegal,
  output logic [TAG_W-1:0]    out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic [XLEN-1:0]       core_result;
  logic                  core_illegal;
  stage_t                core_stage;
  logic                  accept;
  logic                  downstream;
  logic [PIPE_DEPTH-1:0] stage_valid;
  logic [PIPE_DEPTH-1:0] can_take;
  stage_t                stage_data [PIPE_DEPTH];

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .op      (in_op),
    .a       (in_src_a),
    .b       (in_src_b),
    .result  (core_result),
    .illegal (core_illegal)
  );

  assign core_stage = '{result:  core_result,
                        zero:    (core_result == '0),
                        illegal: core_illegal,
                        tag:     in_tag};

  // A stage can load when it is empty or its occupant moves on this cycle.
  always_comb begin
    can_take   = '0;
    downstream = out_ready;
    for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
      can_take[k] = !stage_valid[k] || downstream;
      downstream  = can_take[k];
    end
  end

  assign in_ready = !flush && can_take[0];
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < int'(PIPE_DEPTH); k++) begin : gen_stage
    logic   valid_q;
    logic   valid_in;
    stage_t data_q;
    stage_t data_in;

    if (k == 0) begin : gen_head
      assign valid_in = accept;
      assign data_in  = core_stage;
    end else begin : gen_body
      assign valid_in = stage_valid[k-1];
      assign data_in  = stage_data[k-1];
    end

    // Data only loads alongside a valid op so the output holds its last value when idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (can_take[k]) begin
        valid_q <= valid_in;
        if (valid_in) begin
          data_q <= data_in;
        end
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_data[k]  = data_q;
  end

  assign out_valid   = stage_valid[PIPE_DEPTH-1];
  assign out_result  = stage_data[PIPE_DEPTH-1].result;
  assign out_zero    = stage_data[PIPE_DEPTH-1].zero;
  assign out_illegal = stage_data[PIPE_DEPTH-1].illegal;
  assign out_tag     = stage_data[PIPE_DEPTH-1].tag;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle RV64I/Zba execute ALU.
- Accepts one operation per cycle under a valid/ready handshake and carries a caller tag alongside each operation.
- Adds XOR, shifts, SLT/SLTU and the word ops ADDW/SUBW to the existing Zba set; flags unknown opcodes.
- Sits in the EX stage. Configurable register depth lets the EX stage be retimed without touching the decode/control encodings.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- PIPE_DEPTH, 2, register stages from accept to output; legal range 1..4.
- TAG_W, 5, width of the opaque tag carried with each op (e.g. rd index).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all in-flight ops this cycle
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- in_op  in  5  opcode, encoding alu_op_e
- in_src_a  in  XLEN  operand A
- in_src_b  in  XLEN  operand B
- in_tag  in  TAG_W  tag, returned unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result when out_valid && out_ready
- out_result  out  XLEN  result
- out_zero  out  1  out_result == 0
- out_illegal  out  1  op was unrecognised; out_result is 0
- out_tag  out  TAG_W  tag of the op presented

Behaviour:
- Reset (async assert, sync release): all stage valid bits clear, so out_valid=0. out_result, out_tag, out_zero and out_illegal reset to 0.
- Compute is combinational on the inputs and is captured in stage 1 on accept. Stages 2..PIPE_DEPTH shift data forward.
- Latency is exactly PIPE_DEPTH cycles from the accept edge to out_valid with no stall.
- Stage k advances when stage k+1 is empty or advancing. The last stage advances on out_ready.
- Bubbles collapse: a stalled output does not block upstream stages that have an empty stage ahead of them.
- in_ready = !flush && (stage1 empty || stage1 advancing). in_ready is combinational from out_ready and the valid bits.
- Throughput is 1 op/cycle with out_ready held high. No op is ever dropped or duplicated under back-pressure.
- out_* values are stable while out_valid && !out_ready.
- flush clears every valid bit at the next edge, overriding advance. No accept occurs in a flush cycle.
- SH = log2(XLEN) bits. Shift amounts use in_src_b[SH-1:0]. SLLI.UW uses src_b[SH-1:0].
- Opcodes 0..11 keep the existing encodings:
  - 0 ADD; 1 SUB; 2 AND; 3 OR.
  - 4/5/6 SH1ADD/SH2ADD/SH3ADD: B + (A<<n).
  - 7 ADD.UW; 8/9/10 SHnADD.UW: B + (zext(A[31:0])<<n).
  - 11 SLLI.UW: zext(A[31:0]) << B[SH-1:0].
- New opcodes:
  - 12 XOR; 13 SLL; 14 SRL; 15 SRA (arithmetic).
  - 16 ADDW: sext((A+B)[31:0]). 17 SUBW: sext((A-B)[31:0]).
  - 18 SLT (signed): result 1 or 0. 19 SLTU: result 1 or 0.
- Opcodes 20..31 produce result 0 with out_illegal=1.
- All arithmetic wraps modulo 2^XLEN; no overflow flag.
- XLEN=32: .uw ops use A unmodified, ADDW/SUBW equal ADD/SUB, and SH=5.
- Reset asserted mid-operation discards all in-flight ops. After release, in_ready=1 in the first cycle.

Decomposition:
- Package alu_pkg:
  - alu_op_e (5-bit enum, values above)
  - ALU_OP_W=5
  - helper function is_legal_op()
- Sub-module alu_core: pure combinational (op, a, b) -> (result, illegal), parametrised by XLEN.
- alu_pipe instantiates alu_core and owns the handshake and stage registers, via a generate loop over PIPE_DEPTH.

Test Plan:
- XLEN=64, PIPE_DEPTH=2, out_ready=1. Issue SH2ADD a=0x3, b=0x100, tag=5 -> out_result=0x10C, tag=5, out_valid exactly 2 cycles after accept.
- ADD.UW a=0xFFFF_FFFF_8000_0000, b=1 -> 0x8000_0001. ADDW a=0x7FFF_FFFF, b=1 -> 0xFFFF_FFFF_8000_0000. SRA a=0x8000_0000_0000_0000, b=0x43 (masked to 3) -> 0xF000_0000_0000_0000.
- Back-to-back stream of 8 ADDs with tags 0..7; out_ready low for 4 cycles mid-stream:
  - in_ready drops once both stages are full
  - all 8 results emerge in order, none lost or repeated
  - outputs stay stable during the stall.
- flush while 2 ops are in flight and in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, and neither flushed op ever appears.
- Opcode 25 -> out_illegal=1, out_result=0, out_zero=1. SUB a=b=0x1234 -> out_zero=1, out_illegal=0.
- Repeat the first three scenarios with XLEN=32 / PIPE_DEPTH=1 and PIPE_DEPTH=4. Latency must match PIPE_DEPTH. SLLI.UW a=0x1, b=31 -> 0x8000_0000.
- Drive rst_n low mid-stream -> outputs zero immediately (async); no stale result after release.
